// File: rtl/pan_sequencer_if.sv
// pan_sequencer_if: host request/response channel (request PAN in, result record out)
interface pan_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_len;
  logic [75:0] req_bcd;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_status;
  logic        res_luhn_ok;
  logic [2:0]  res_brand;
  logic [4:0]  res_issuer;
  logic [1:0]  res_type;
  logic        res_hit;
  modport master (
    output req_valid, req_len, req_bcd, res_ready,
    input  req_ready, res_valid, res_status, res_luhn_ok, res_brand, res_issuer, res_type, res_hit
  );
  modport slave (
    input  req_valid, req_len, req_bcd, res_ready,
    output req_ready, res_valid, res_status, res_luhn_ok, res_brand, res_issuer, res_type, res_hit
  );
endinterface

// File: rtl/pan_sequencer.sv
// pan_sequencer: paces a buffered PAN into pan_stream, collects Luhn/IIN results, returns one status record
module pan_sequencer #(
  parameter int DIGIT_GAP = 1,
  parameter int TIMEOUT   = 64,
  parameter int MIN_LEN   = 12,
  parameter int MAX_LEN   = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  pan_sequencer_if.slave        host,
  output logic                  ps_start,
  output logic                  ps_digit_valid,
  output logic [3:0]            ps_digit_in,
  output logic                  ps_pan_end,
  output logic                  ps_abort,
  input  logic                  ps_card_done,
  input  logic                  ps_error_flag,
  input  logic                  luhn_valid,
  input  logic                  meta_valid,
  input  logic [2:0]            brand_id,
  input  logic [4:0]            issuer_id,
  input  logic [1:0]            type_id,
  input  logic                  meta_hit
);
  localparam int GW = DIGIT_GAP > 0 ? $clog2(DIGIT_GAP + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK = 2'd0, ST_LEN = 2'd1, ST_STREAM = 2'd2, ST_TIMEOUT = 2'd3;
  typedef enum logic [2:0] {IDLE, START, SEND, GAP, END, WAIT, ABORT, RESP} state_t;
  state_t         state, state_n;
  logic [4:0]     len, k;
  logic [75:0]    bcd;
  logic [GW-1:0]  gcnt;
  logic [TW-1:0]  tcnt;
  logic           done_seen, meta_seen, luhn_r, hit_r;
  logic [1:0]     status, type_r;
  logic [2:0]     brand_r;
  logic [4:0]     issuer_r;
  logic           len_ok, last, gap_done, tmo, err, both;
  assign len_ok   = host.req_len >= 5'(MIN_LEN) && host.req_len <= 5'(MAX_LEN);
  assign last     = k == len - 5'd1;
  assign gap_done = gcnt == GW'(DIGIT_GAP - 1);
  assign tmo      = tcnt == TW'(TIMEOUT - 1);
  assign err      = ps_error_flag && state inside {SEND, GAP, END, WAIT};
  assign both     = (done_seen || ps_card_done) && (meta_seen || meta_valid);
  assign host.req_ready   = state == IDLE;
  assign host.res_valid   = state == RESP;
  assign host.res_status  = status;
  assign host.res_luhn_ok = luhn_r;
  assign host.res_brand   = brand_r;
  assign host.res_issuer  = issuer_r;
  assign host.res_type    = type_r;
  assign host.res_hit     = hit_r;
  assign ps_start       = state == START;
  assign ps_digit_valid = state == SEND;
  assign ps_digit_in    = ps_digit_valid ? bcd[{k, 2'b00} +: 4] : 4'd0;
  assign ps_pan_end     = state == END;
  assign ps_abort       = state == ABORT;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = host.req_valid ? (len_ok ? START : RESP) : IDLE;
      START:   state_n = SEND;
      SEND:    state_n = err ? ABORT : DIGIT_GAP > 0 ? GAP : last ? END : SEND;
      GAP:     state_n = err ? ABORT : !gap_done ? GAP : last ? END : SEND;
      END:     state_n = err ? ABORT : WAIT;
      WAIT:    state_n = err ? ABORT : both ? RESP : tmo ? ABORT : WAIT;
      ABORT:   state_n = RESP;
      RESP:    state_n = host.res_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      bcd       <= '0;
      k         <= '0;
      gcnt      <= '0;
      tcnt      <= '0;
      done_seen <= 1'b0;
      meta_seen <= 1'b0;
      luhn_r    <= 1'b0;
      brand_r   <= '0;
      issuer_r  <= '0;
      type_r    <= '0;
      hit_r     <= 1'b0;
      status    <= ST_OK;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (host.req_valid) begin
          len       <= host.req_len;
          bcd       <= host.req_bcd;
          k         <= '0;
          done_seen <= 1'b0;
          meta_seen <= 1'b0;
          luhn_r    <= 1'b0;
          brand_r   <= '0;
          issuer_r  <= '0;
          type_r    <= '0;
          hit_r     <= 1'b0;
          status    <= len_ok ? ST_OK : ST_LEN;
        end
        SEND: begin
          gcnt <= '0;
          k    <= DIGIT_GAP == 0 ? k + 5'd1 : k;
        end
        GAP: begin
          gcnt <= gcnt + 1'b1;
          k    <= gap_done ? k + 5'd1 : k;
        end
        END: tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (ps_card_done) begin
            done_seen <= 1'b1;
            luhn_r    <= luhn_valid;
          end
          if (meta_valid) begin
            meta_seen <= 1'b1;
            brand_r   <= brand_id;
            issuer_r  <= issuer_id;
            type_r    <= type_id;
            hit_r     <= meta_hit;
          end
        end
        ABORT: begin
          luhn_r   <= 1'b0;
          brand_r  <= '0;
          issuer_r <= '0;
          type_r   <= '0;
          hit_r    <= 1'b0;
        end
        default: ;
      endcase
      if (state_n == ABORT && state != ABORT) status <= err ? ST_STREAM : ST_TIMEOUT;
    end
  end
endmodule
